// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the RV32I instruction decoder: the major opcodes,
// the ALU operation and immediate format encodings seen on the decoder
// outputs, and a helper that maps funct3 onto the base ALU operation shared
// by the OP and OP-IMM groups.
package decoder_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    // The register and immediate arithmetic groups share one funct3 layout;
    // the funct7 alternate (SUB/SRA) is layered on top by the caller.
    function automatic alu_op_e baseAluOp(input logic [2:0] funct3);
        case (funct3)
            3'd0:    baseAluOp = ALU_ADD;
            3'd1:    baseAluOp = ALU_SLL;
            3'd2:    baseAluOp = ALU_SLT;
            3'd3:    baseAluOp = ALU_SLTU;
            3'd4:    baseAluOp = ALU_XOR;
            3'd5:    baseAluOp = ALU_SRL;
            3'd6:    baseAluOp = ALU_OR;
            default: baseAluOp = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decoder_alu_op_decode.sv
// alu_op_decode
// Combinational map from opcode/funct3/funct7 to the ALU operation, plus a
// flag saying the funct fields (and the opcode itself) form a supported
// encoding. An unknown opcode reports functOk_o = 0.
// Ports:
//   opcode_i   instr[6:0]
//   funct3_i   instr[14:12]
//   funct7_i   instr[31:25]
//   aluOp_o    ALU operation
//   functOk_o  1 when the encoding is supported
module alu_op_decode
    import decoder_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_e    aluOp_o,
    output logic       functOk_o
);

    // Select the ALU operation and judge funct-field legality per opcode.
    // Defaults make every unlisted opcode illegal with a harmless ADD.
    always_comb begin
        aluOp_o   = ALU_ADD;
        functOk_o = 1'b0;
        case (opcode_i)
            OPC_LOAD: begin
                aluOp_o   = ALU_ADD;
                functOk_o = !((funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11));
            end
            OPC_STORE: begin
                aluOp_o   = ALU_ADD;
                functOk_o = (funct3_i < 3'd3);
            end
            OPC_OP: begin
                aluOp_o = baseAluOp(funct3_i);
                if (funct7_i == F7_BASE) begin
                    functOk_o = 1'b1;
                end else if ((funct7_i == F7_ALT) && (funct3_i == 3'd0)) begin
                    aluOp_o   = ALU_SUB;
                    functOk_o = 1'b1;
                end else if ((funct7_i == F7_ALT) && (funct3_i == 3'd5)) begin
                    aluOp_o   = ALU_SRA;
                    functOk_o = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                aluOp_o = baseAluOp(funct3_i);
                if (funct3_i == 3'd1) begin
                    functOk_o = (funct7_i == F7_BASE);
                end else if (funct3_i == 3'd5) begin
                    functOk_o = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
                    if (funct7_i == F7_ALT) begin
                        aluOp_o = ALU_SRA;
                    end
                end else begin
                    functOk_o = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // Pairs of funct3 codes share a comparison: EQ/NE, LT/GE, LTU/GEU.
                case (funct3_i[2:1])
                    2'b00:   begin aluOp_o = ALU_SUB;  functOk_o = 1'b1; end
                    2'b10:   begin aluOp_o = ALU_SLT;  functOk_o = 1'b1; end
                    2'b11:   begin aluOp_o = ALU_SLTU; functOk_o = 1'b1; end
                    default: begin aluOp_o = ALU_ADD;  functOk_o = 1'b0; end
                endcase
            end
            OPC_JAL: begin
                aluOp_o   = ALU_ADD;
                functOk_o = 1'b1;
            end
            OPC_JALR: begin
                aluOp_o   = ALU_ADD;
                functOk_o = (funct3_i == 3'd0);
            end
            OPC_LUI: begin
                aluOp_o   = ALU_PASSB;
                functOk_o = 1'b1;
            end
            OPC_AUIPC: begin
                aluOp_o   = ALU_ADD;
                functOk_o = 1'b1;
            end
            default: begin
                aluOp_o   = ALU_ADD;
                functOk_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decoder.sv
// decoder
// RV32I instruction decoder with registered outputs (one clock of latency).
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset, clears all outputs
//   instr     32-bit instruction word
//   memWrite  store to data memory
//   regWrite  write rd
//   aluSrc    ALU operand B: 1 = rs2, 0 = immediate
//   memToReg  writeback: 1 = load data, 0 = ALU result
//   aluOp     ALU operation (alu_op_e)
//   immType   immediate format (imm_type_e)
//   branch    conditional branch
//   jump      JAL/JALR
//   illegal   unsupported or malformed encoding
module decoder
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        memWrite,
    output logic        regWrite,
    output logic        aluSrc,
    output logic        memToReg,
    output logic [3:0]  aluOp,
    output logic [2:0]  immType,
    output logic        branch,
    output logic        jump,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    alu_op_e    decAluOp;
    logic       functOk;
    logic       unusedFields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register and immediate fields are consumed elsewhere in the core.
    assign unusedFields = ^{instr[24:15], instr[11:7]};

    logic      memWrite_d, regWrite_d, aluSrc_d, memToReg_d;
    logic      branch_d, jump_d, illegal_d;
    alu_op_e   aluOp_d;
    imm_type_e immType_d;

    logic      memWrite_q, regWrite_q, aluSrc_q, memToReg_q;
    logic      branch_q, jump_q, illegal_q;
    alu_op_e   aluOp_q;
    imm_type_e immType_q;

    alu_op_decode uAluOpDecode (
        .opcode_i  (opcode),
        .funct3_i  (funct3),
        .funct7_i  (funct7),
        .aluOp_o   (decAluOp),
        .functOk_o (functOk)
    );

    // Per-opcode control fields. Any illegal encoding (bad opcode, bad
    // funct fields, or low bits not 11, which no listed opcode matches)
    // collapses every control output to 0 and raises only illegal.
    always_comb begin
        memWrite_d = 1'b0;
        regWrite_d = 1'b0;
        aluSrc_d   = 1'b0;
        memToReg_d = 1'b0;
        branch_d   = 1'b0;
        jump_d     = 1'b0;
        illegal_d  = 1'b0;
        aluOp_d    = decAluOp;
        immType_d  = IMM_I;
        case (opcode)
            OPC_LOAD: begin
                regWrite_d = 1'b1;
                memToReg_d = 1'b1;
            end
            OPC_STORE: begin
                memWrite_d = 1'b1;
                immType_d  = IMM_S;
            end
            OPC_OP: begin
                regWrite_d = 1'b1;
                aluSrc_d   = 1'b1;
            end
            OPC_OP_IMM: begin
                regWrite_d = 1'b1;
            end
            OPC_BRANCH: begin
                branch_d  = 1'b1;
                aluSrc_d  = 1'b1;
                immType_d = IMM_B;
            end
            OPC_JAL: begin
                jump_d     = 1'b1;
                regWrite_d = 1'b1;
                immType_d  = IMM_J;
            end
            OPC_JALR: begin
                jump_d     = 1'b1;
                regWrite_d = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                regWrite_d = 1'b1;
                immType_d  = IMM_U;
            end
            default: begin
                regWrite_d = 1'b0;
            end
        endcase
        if (!functOk) begin
            memWrite_d = 1'b0;
            regWrite_d = 1'b0;
            aluSrc_d   = 1'b0;
            memToReg_d = 1'b0;
            branch_d   = 1'b0;
            jump_d     = 1'b0;
            aluOp_d    = ALU_ADD;
            immType_d  = IMM_I;
            illegal_d  = 1'b1;
        end
    end

    // Output register; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memWrite_q <= 1'b0;
            regWrite_q <= 1'b0;
            aluSrc_q   <= 1'b0;
            memToReg_q <= 1'b0;
            branch_q   <= 1'b0;
            jump_q     <= 1'b0;
            illegal_q  <= 1'b0;
            aluOp_q    <= ALU_ADD;
            immType_q  <= IMM_I;
        end else begin
            memWrite_q <= memWrite_d;
            regWrite_q <= regWrite_d;
            aluSrc_q   <= aluSrc_d;
            memToReg_q <= memToReg_d;
            branch_q   <= branch_d;
            jump_q     <= jump_d;
            illegal_q  <= illegal_d;
            aluOp_q    <= aluOp_d;
            immType_q  <= immType_d;
        end
    end

    assign memWrite = memWrite_q;
    assign regWrite = regWrite_q;
    assign aluSrc   = aluSrc_q;
    assign memToReg = memToReg_q;
    assign branch   = branch_q;
    assign jump     = jump_q;
    assign illegal  = illegal_q;
    assign aluOp    = aluOp_q;
    assign immType  = immType_q;

endmodule

// File: tb/tb_decoder.sv
// tb_decoder
// Scoreboard bench for the RV32I decoder: stimulus pushes the reference
// model's prediction into a queue, a monitor pops and compares one clock later.
module tb_decoder;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        memWrite, regWrite, aluSrc, memToReg, branch, jump, illegal;
    logic [3:0]  aluOp;
    logic [2:0]  immType;

    logic        instrValid;
    logic [13:0] expectQ[$];
    logic [31:0] instrQ[$];
    int          vectors;
    int          miscompares;

    decoder dut (
        .clk      (clock),
        .reset    (reset),
        .instr    (instr),
        .memWrite (memWrite),
        .regWrite (regWrite),
        .aluSrc   (aluSrc),
        .memToReg (memToReg),
        .aluOp    (aluOp),
        .immType  (immType),
        .branch   (branch),
        .jump     (jump),
        .illegal  (illegal)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view of the DUT outputs in the reference model's field order.
    function automatic logic [13:0] dutView();
        return {illegal, memWrite, regWrite, aluSrc, memToReg, aluOp, immType, branch, jump};
    endfunction

    // Reference model written from the ISA rules: legality as set membership
    // on funct3/funct7, ALU operation via lookup tables.
    function automatic logic [13:0] refDecode(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok, mw, rw, src, m2r, br, jp;
        int         alu, imm;
        int         arithTable[8];
        int         branchTable[8];
        arithTable  = '{0, 2, 3, 4, 5, 6, 8, 9};
        branchTable = '{1, 1, 0, 0, 3, 3, 4, 4};
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 0; mw = 0; rw = 0; src = 0; m2r = 0; br = 0; jp = 0;
        alu = 0; imm = 0;
        case (op)
            7'h03: begin ok = !(f3 inside {3'd3, 3'd6, 3'd7}); rw = 1; m2r = 1; end
            7'h23: begin ok = (f3 <= 2); mw = 1; imm = 1; end
            7'h33: begin
                ok  = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                rw  = 1; src = 1;
                alu = arithTable[f3] + ((f7 == 7'h20) ? 1 : 0);
            end
            7'h13: begin
                if (f3 == 1)      ok = (f7 == 0);
                else if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
                else              ok = 1;
                rw  = 1;
                alu = arithTable[f3] + ((f3 == 5 && f7 == 7'h20) ? 1 : 0);
            end
            7'h63: begin ok = !(f3 inside {3'd2, 3'd3}); br = 1; src = 1; imm = 2; alu = branchTable[f3]; end
            7'h6F: begin ok = 1; jp = 1; rw = 1; imm = 4; end
            7'h67: begin ok = (f3 == 0); jp = 1; rw = 1; end
            7'h37: begin ok = 1; rw = 1; imm = 3; alu = 10; end
            7'h17: begin ok = 1; rw = 1; imm = 3; end
            default: ok = 0;
        endcase
        if (!ok) return 14'b1_0000_0000_0000_0;
        return {1'b0, mw, rw, src, m2r, alu[3:0], imm[2:0], br, jp};
    endfunction

    // Drive one instruction just after a rising edge and record its prediction.
    task automatic applyStimulus(input logic [31:0] w);
        @(posedge clock);
        #1;
        instr      = w;
        instrValid = 1'b1;
        expectQ.push_back(refDecode(w));
        instrQ.push_back(w);
    endtask

    // Single comparison with counting and a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] w,
                               input logic [13:0] got, input logic [13:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s instr=%h got=%b want=%b", name, w, got, want);
        end
    endtask

    // Monitor: an instruction valid at a rising edge is visible on the
    // outputs shortly after that edge.
    initial begin
        logic        wasValid;
        logic [13:0] want;
        logic [31:0] w;
        forever begin
            @(posedge clock);
            wasValid = instrValid;
            #2;
            if (wasValid) begin
                if (expectQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL scoreboard underflow got=%b want=none", dutView());
                end else begin
                    want = expectQ.pop_front();
                    w    = instrQ.pop_front();
                    checkOutput("decode", w, dutView(), want);
                end
            end
        end
    end

    // Random instruction biased toward the defined opcodes and funct7 values.
    function automatic logic [31:0] randomInstr();
        logic [6:0] ops[9];
        logic [31:0] w;
        int pick;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        w = $urandom;
        pick = $urandom_range(0, 10);
        if (pick < 9) w[6:0] = ops[pick];
        pick = $urandom_range(0, 3);
        if (pick == 0)      w[31:25] = 7'h00;
        else if (pick == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    initial begin
        logic [31:0] directed[10];
        int          drain;
        directed = '{32'h00002003, 32'h00000033, 32'h00102023, 32'h40000033,
                     32'h40005033, 32'h00004063, 32'h0000006F, 32'h00000000,
                     32'h40001033, 32'h00007003};
        vectors     = 0;
        miscompares = 0;
        instrValid  = 1'b0;
        instr       = 32'h00000033;
        reset       = 1'b1;

        repeat (2) @(posedge clock);
        #2;
        checkOutput("resetState", instr, dutView(), 14'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] directed vectors");
        foreach (directed[i]) applyStimulus(directed[i]);

        $display("[TB] random vectors");
        for (int n = 0; n < 300; n++) applyStimulus(randomInstr());

        // Mid-stream asynchronous reset with a valid load applied.
        applyStimulus(32'h00002003);
        @(posedge clock);
        #1;
        instrValid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncReset", instr, dutView(), 14'd0);
        @(posedge clock);
        #2;
        checkOutput("resetHeld", instr, dutView(), 14'd0);
        @(negedge clock);
        reset      = 1'b0;
        instrValid = 1'b1;
        expectQ.push_back(refDecode(instr));
        instrQ.push_back(instr);
        @(posedge clock);
        #1;
        instrValid = 1'b0;

        drain = 0;
        while (expectQ.size() != 0 && drain < 20) begin
            @(posedge clock);
            drain++;
        end
        if (expectQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain timeout got=%0d pending want=0", expectQ.size());
        end
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
